fp32_divider: RTL and testbench

Sequential IEEE-754 single-precision divider computing `a_i / b_i` by restoring division, one quotient bit per cycle. It is the inverse-operation companion to the FP32 multiplier. It uses the same start/done handshake and flag set, plus a divide-by-zero flag and a busy indicator. Rounding is truncation (toward zero). Subnormal inputs are flushed to signed zero; subnormal results are flushed to zero with `underflow_o` set.

---
 rtl/fp32_pkg.sv | 18 +
 rtl/fp32_classify.sv | 25 ++
 rtl/fp32_divider.sv | 206 ++++++++++++++++++++
 tb/tb_fp32_divider.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the sequential divider and multiplier:
// FSM state encoding and format constants.
package fp32_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNPACK    = 3'd1,
    DIVIDE    = 3'd2,
    NORMALIZE = 3'd3,
    DONE      = 3'd4
  } state_e;

  localparam int               MANT_W   = 24;
  localparam logic signed [9:0] EXP_BIAS = 10'sd127;
  localparam logic [7:0]       EXP_MAX  = 8'hFF;
  localparam logic [31:0]      QNAN     = 32'h7FC00000;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand decoder: splits fields and classifies the value.
// Subnormals (exp=0) are reported as zero, so the hidden bit is always 1.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0]       op_i,
  output logic              sign_o,
  output logic [7:0]        exp_o,
  output logic [MANT_W-1:0] mant_o,
  output logic              is_zero_o,
  output logic              is_inf_o,
  output logic              is_nan_o
);

  // field extraction and class decode
  always_comb begin
    sign_o    = op_i[31];
    exp_o     = op_i[30:23];
    mant_o    = {1'b1, op_i[22:0]};
    is_zero_o = (op_i[30:23] == 8'h00);
    is_inf_o  = (op_i[30:23] == EXP_MAX) && (op_i[22:0] == 23'h000000);
    is_nan_o  = (op_i[30:23] == EXP_MAX) && (op_i[22:0] != 23'h000000);
  end

endmodule

// File: rtl/fp32_divider.sv
// Sequential FP32 divider: restoring division, one quotient bit per cycle,
// truncating result, subnormals flushed to zero.
module fp32_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quotient_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        nan_o,
  output logic        infinit_o,
  output logic        div_by_zero_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  state_e state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [25:0] rem_q, rem_d, rem_sub_s;
  logic [24:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic signed [9:0] exp_q, exp_d, exp_adj_s;
  logic        sign_q, sign_d, done_q, done_d, busy_q, busy_d;
  logic [4:0]  flags_q, flags_d;  // {nan, inf, div_by_zero, overflow, underflow}
  logic [22:0] frac_s;
  logic        rem_ge_s, nan_case_s, special_s, sign_s;

  logic              a_sign_s, b_sign_s, a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [7:0]        a_exp_s, b_exp_s;
  logic [MANT_W-1:0] a_mant_s, b_mant_s;

  fp32_classify u_cls_a (
    .op_i(a_q), .sign_o(a_sign_s), .exp_o(a_exp_s), .mant_o(a_mant_s),
    .is_zero_o(a_zero_s), .is_inf_o(a_inf_s), .is_nan_o(a_nan_s)
  );

  fp32_classify u_cls_b (
    .op_i(b_q), .sign_o(b_sign_s), .exp_o(b_exp_s), .mant_o(b_mant_s),
    .is_zero_o(b_zero_s), .is_inf_o(b_inf_s), .is_nan_o(b_nan_s)
  );

  // special-case detection, restoring step and normalisation helpers
  always_comb begin
    sign_s     = a_sign_s ^ b_sign_s;
    nan_case_s = a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s);
    special_s  = nan_case_s | a_inf_s | b_inf_s | a_zero_s | b_zero_s;
    rem_ge_s   = (rem_q >= {2'b00, b_mant_s});
    if (rem_ge_s) begin
      rem_sub_s = rem_q - {2'b00, b_mant_s};
    end else begin
      rem_sub_s = rem_q;
    end
    if (quo_q[24]) begin
      frac_s    = quo_q[23:1];
      exp_adj_s = exp_q;
    end else begin
      frac_s    = quo_q[22:0];
      exp_adj_s = exp_q - 10'sd1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_i) state_d = UNPACK; else state_d = IDLE;
      UNPACK:    if (special_s) state_d = DONE; else state_d = DIVIDE;
      DIVIDE:    if (cnt_q == 5'd0) state_d = NORMALIZE; else state_d = DIVIDE;
      NORMALIZE: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // datapath and output next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    res_d   = res_q;
    flags_d = flags_q;
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          res_d   = 32'h00000000;
          flags_d = 5'b00000;
        end else begin
          a_d = a_q;
        end
      end
      UNPACK: begin
        sign_d = sign_s;
        rem_d  = {2'b00, a_mant_s};
        quo_d  = 25'h0000000;
        cnt_d  = 5'd24;
        exp_d  = $signed({2'b00, a_exp_s}) - $signed({2'b00, b_exp_s}) + EXP_BIAS;
        // priority order matters: e.g. inf/0 reports infinity, not divide-by-zero
        if (nan_case_s) begin
          res_d   = QNAN;
          flags_d = 5'b10000;
        end else if (a_inf_s) begin
          res_d   = {sign_s, EXP_MAX, 23'h000000};
          flags_d = 5'b01000;
        end else if (b_inf_s) begin
          res_d   = {sign_s, 8'h00, 23'h000000};
          flags_d = 5'b01000;
        end else if (b_zero_s) begin
          res_d   = {sign_s, EXP_MAX, 23'h000000};
          flags_d = 5'b00100;
        end else if (a_zero_s) begin
          res_d   = {sign_s, 8'h00, 23'h000000};
          flags_d = 5'b00000;
        end else begin
          res_d = res_q;
        end
      end
      DIVIDE: begin
        rem_d = rem_sub_s << 1;
        quo_d = {quo_q[23:0], rem_ge_s};
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      NORMALIZE: begin
        if (exp_adj_s >= 10'sd255) begin
          res_d   = {sign_q, EXP_MAX, 23'h000000};
          flags_d = 5'b00010;
        end else if (exp_adj_s <= 10'sd0) begin
          res_d   = {sign_q, 8'h00, 23'h000000};
          flags_d = 5'b00001;
        end else begin
          res_d   = {sign_q, exp_adj_s[7:0], frac_s};
          flags_d = 5'b00000;
        end
      end
      DONE: begin
        res_d = res_q;
      end
      default: begin
        res_d = res_q;
      end
    endcase
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= 32'h00000000;
      b_q     <= 32'h00000000;
      rem_q   <= 26'h0000000;
      quo_q   <= 25'h0000000;
      cnt_q   <= 5'd0;
      exp_q   <= 10'sd0;
      sign_q  <= 1'b0;
      res_q   <= 32'h00000000;
      flags_q <= 5'b00000;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign quotient_o    = res_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign nan_o         = flags_q[4];
  assign infinit_o     = flags_q[3];
  assign div_by_zero_o = flags_q[2];
  assign overflow_o    = flags_q[1];
  assign underflow_o   = flags_q[0];

endmodule

// File: tb/tb_fp32_divider.sv
// Self-checking bench for fp32_divider: directed cases pinned to literal values,
// then randomized operands compared against an arithmetic reference model.
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] a_i = 32'h0;
  logic [31:0] b_i = 32'h0;
  logic [31:0] quotient_o;
  logic        done_o, busy_o, nan_o, infinit_o, div_by_zero_o, overflow_o, underflow_o;

  fp32_divider dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .quotient_o(quotient_o), .done_o(done_o), .busy_o(busy_o), .nan_o(nan_o),
    .infinit_o(infinit_o), .div_by_zero_o(div_by_zero_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        special;
    logic [4:0]  flags;  // {nan, inf, div_by_zero, overflow, underflow}
    logic [31:0] q;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  exp_t cur;
  logic pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: exact integer quotient of the mantissas, then IEEE field rules.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int ea, eb, e;
    longint ma, mb, q;
    logic s;
    logic [22:0] frac;
    bit an, ai, az, bn, bi, bz;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    s = a[31] ^ b[31];
    r.special = 1'b1;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r.flags = 5'b10000; r.q = 32'h7FC00000; return r;
    end
    if (ai) begin r.flags = 5'b01000; r.q = {s, 8'hFF, 23'h0}; return r; end
    if (bi) begin r.flags = 5'b01000; r.q = {s, 31'h0}; return r; end
    if (bz) begin r.flags = 5'b00100; r.q = {s, 8'hFF, 23'h0}; return r; end
    if (az) begin r.flags = 5'b00000; r.q = {s, 31'h0}; return r; end
    r.special = 1'b0;
    ma = longint'(a[22:0]) + 64'd8388608;
    mb = longint'(b[22:0]) + 64'd8388608;
    q  = (ma * 64'd16777216) / mb;
    e  = ea - eb + 127;
    if (q >= 64'd16777216) begin
      frac = 23'((q / 2) % 64'd8388608);
    end else begin
      frac = 23'(q % 64'd8388608);
      e = e - 1;
    end
    if (e >= 255) begin
      r.flags = 5'b00010; r.q = {s, 8'hFF, 23'h0};
    end else if (e <= 0) begin
      r.flags = 5'b00001; r.q = {s, 31'h0};
    end else begin
      r.flags = 5'b00000; r.q = {s, 8'(e), frac};
    end
    return r;
  endfunction

  // result/flag checker: every done_o pulse must carry the expected answer
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (!pending) begin
        check("spurious_done", {63'h0, done_o}, 64'h0);
      end else begin
        check("quotient", quotient_o, cur.q);
        check("flags", {nan_o, infinit_o, div_by_zero_o, overflow_o, underflow_o}, cur.flags);
        pending = 1'b0;
      end
    end
  end

  // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject);
    int  c;
    bit  got;
    cur = model(a, b);
    pending = 1'b1;
    a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom;
    check("clear_on_accept",
          {quotient_o, nan_o, infinit_o, div_by_zero_o, overflow_o, underflow_o}, 64'h0);
    c = 1; got = 0;
    while (!got && c <= 40) begin
      check("busy", {63'h0, busy_o}, 64'h1);
      if (done_o) begin
        got = 1;
      end else begin
        if (inject && c == 10) begin
          start_i = 1'b1; a_i = 32'h3F800000; b_i = 32'h40400000;
        end else begin
          start_i = 1'b0;
        end
        @(negedge clk);
        c++;
      end
    end
    start_i = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout actual=no_done required=done a=%h b=%h", a, b);
      pending = 1'b0;
    end else begin
      check("latency", c, cur.special ? 64'd2 : 64'd28);
    end
    @(negedge clk);
    check("idle_after_done", {62'h0, done_o, busy_o}, 64'h0);
    check("hold_result", quotient_o, cur.q);
  endtask

  task automatic pin(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lq,
                     input logic [4:0] lf, input logic ls);
    exp_t m;
    m = model(a, b);
    check("model_pin", m, {ls, lf, lq});
    run_op(a, b, 1'b0);
  endtask

  function automatic logic [31:0] rand_op();
    int r;
    logic [7:0] e;
    logic [22:0] f;
    r = $urandom_range(0, 9);
    f = 23'($urandom);
    if (r == 0) e = 8'h00;
    else if (r == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = 23'h0; end
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f};
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", {quotient_o, done_o, busy_o, nan_o, infinit_o,
                            div_by_zero_o, overflow_o, underflow_o}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    pin(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b0);
    pin(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5'b00000, 1'b0);
    pin(32'hBF800000, 32'h00000000, 32'hFF800000, 5'b00100, 1'b1);
    pin(32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b1);
    pin(32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1'b1);
    pin(32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00010, 1'b0);
    pin(32'h00800000, 32'h40000000, 32'h00000000, 5'b00001, 1'b0);
    pin(32'h7F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1'b1);
    pin(32'hC0000000, 32'h7F800000, 32'h80000000, 5'b01000, 1'b1);

    // a start pulse in the middle of DIVIDE must be ignored
    run_op(32'h40C00000, 32'h40000000, 1'b1);

    // asynchronous reset during DIVIDE, then a clean operation
    a_i = 32'h40C00000; b_i = 32'h40000000; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    pending = 1'b0;
    #1;
    check("reset_mid_op", {quotient_o, done_o, busy_o, nan_o, infinit_o,
                           div_by_zero_o, overflow_o, underflow_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h40C00000, 32'h40000000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(rand_op(), rand_op(), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
